// File: rtl/alu_mc.sv
// alu_mc: multi-cycle RV32I/RV32M ALU with a registered, valid/ready handshaked result.
// Latency: base ops, illegal opcodes and divide special cases take 1 cycle; MUL/DIV/REM take XLEN+1 cycles.
// Backpressure: in_ready is low while an op is iterating or a result is held with out_ready low.
// Ports: clk/rst (sync, active high); in_valid/in_ready with alu_ctrl, operand1, operand2;
//        out_valid/out_ready with alu_out, out_illegal.
module alu_mc #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            out_illegal
);

    localparam int SW = $clog2(XLEN);

    localparam logic [XLEN-1:0]   ZERO     = '0;
    localparam logic [XLEN-1:0]   ONES     = '1;
    localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ZERO2    = '0;
    localparam logic [SW-1:0]     CNT_LAST = SW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;          // funct3 of the captured M op
    logic                neg_q, neg_d;        // negate product / quotient at the end
    logic                neg_rem_q, neg_rem_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;        // product accumulator
    logic [2*XLEN-1:0]   mcand_q, mcand_d;    // multiplicand, shifted left each step
    logic [XLEN-1:0]     shreg_q, shreg_d;    // multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]     divisor_q, divisor_d;
    logic [XLEN-1:0]     rem_q, rem_d;        // partial remainder
    logic [XLEN-1:0]     alu_out_q, alu_out_d;
    logic                out_illegal_q, out_illegal_d;
    logic                out_valid_q, out_valid_d;

    logic                accept;
    logic [SW-1:0]       shamt;
    logic [XLEN-1:0]     base_res;
    logic                base_ok;

    logic                m_ok;
    logic                is_mul;
    logic                is_rem;
    logic                div_signed;
    logic                sgn_a, sgn_b;
    logic                neg_a, neg_b;
    logic [XLEN-1:0]     a_mag, b_mag;
    logic                div_zero, div_ovf;
    logic [XLEN-1:0]     div_special_res;

    logic [XLEN:0]       div_part, div_trial;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix;
    logic [XLEN-1:0]     done_res;

    // A new op may enter only when idle and the output register is free or draining now.
    assign in_ready    = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign alu_out     = alu_out_q;
    assign out_illegal = out_illegal_q;

    assign shamt = operand2[SW-1:0];

    // Single-cycle base operations.
    always_comb begin
        base_res = ZERO;
        base_ok  = 1'b1;
        case (alu_ctrl[3:0])
            4'b0000: base_res = operand1 + operand2;
            4'b1000: base_res = operand1 - operand2;
            4'b0100: base_res = operand1 ^ operand2;
            4'b0110: base_res = operand1 | operand2;
            4'b0111: base_res = operand1 & operand2;
            4'b0001: base_res = operand1 << shamt;
            4'b0101: base_res = operand1 >> shamt;
            4'b1101: base_res = XLEN'($signed(operand1) >>> shamt);
            4'b0010: base_res = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
            default: base_ok  = 1'b0;
        endcase
    end

    // M-op decode and operand sign handling. Both the multiplier and the divider
    // work on magnitudes; the sign of the final result is restored in DONE.
    always_comb begin
        m_ok       = ENABLE_M && !alu_ctrl[3];
        is_mul     = !alu_ctrl[2];
        is_rem     = alu_ctrl[1];
        div_signed = !alu_ctrl[0];
        if (is_mul) begin
            // MULH: s*s, MULHSU: s*u; MUL and MULHU treat both as unsigned
            // (the low half of the product does not depend on signedness).
            sgn_a = (alu_ctrl[1:0] == 2'b01) || (alu_ctrl[1:0] == 2'b10);
            sgn_b = (alu_ctrl[1:0] == 2'b01);
        end else begin
            sgn_a = div_signed;
            sgn_b = div_signed;
        end
        neg_a = sgn_a && operand1[XLEN-1];
        neg_b = sgn_b && operand2[XLEN-1];
        a_mag = neg_a ? (ZERO - operand1) : operand1;
        b_mag = neg_b ? (ZERO - operand2) : operand2;

        div_zero = (operand2 == ZERO);
        div_ovf  = div_signed && (operand1 == MOST_NEG) && (operand2 == ONES);
        if (div_zero) begin
            div_special_res = is_rem ? operand1 : ONES;
        end else begin
            div_special_res = is_rem ? ZERO : operand1;
        end
    end

    // One restoring-division step: shift in the next dividend bit, try to subtract.
    always_comb begin
        div_part  = {rem_q, shreg_q[XLEN-1]};
        div_trial = div_part - {1'b0, divisor_q};
    end

    // Final sign fix-up and result selection for iterative ops.
    always_comb begin
        prod_fix = neg_q ? (ZERO2 - acc_q) : acc_q;
        quo_fix  = neg_q ? (ZERO - shreg_q) : shreg_q;
        rem_fix  = neg_rem_q ? (ZERO - rem_q) : rem_q;
        if (!op_q[2]) begin
            done_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else begin
            done_res = op_q[1] ? rem_fix : quo_fix;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        neg_d         = neg_q;
        neg_rem_d     = neg_rem_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        shreg_d       = shreg_q;
        divisor_d     = divisor_q;
        rem_d         = rem_q;
        alu_out_d     = alu_out_q;
        out_illegal_d = out_illegal_q;
        out_valid_d   = out_valid_q;

        // A consumed result is dropped unless a new one is loaded below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    op_d  = alu_ctrl[2:0];
                    if (!alu_ctrl[4] && base_ok) begin
                        alu_out_d     = base_res;
                        out_illegal_d = 1'b0;
                        out_valid_d   = 1'b1;
                    end else if (!alu_ctrl[4] || !m_ok) begin
                        alu_out_d     = ZERO;
                        out_illegal_d = 1'b1;
                        out_valid_d   = 1'b1;
                    end else if (is_mul) begin
                        acc_d   = ZERO2;
                        mcand_d = {ZERO, a_mag};
                        shreg_d = b_mag;
                        neg_d   = neg_a ^ neg_b;
                        state_d = MUL;
                    end else if (div_zero || div_ovf) begin
                        alu_out_d     = div_special_res;
                        out_illegal_d = 1'b0;
                        out_valid_d   = 1'b1;
                    end else begin
                        rem_d     = ZERO;
                        shreg_d   = a_mag;
                        divisor_d = b_mag;
                        neg_d     = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        state_d   = DIV;
                    end
                end
            end

            MUL: begin
                if (shreg_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + SW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DIV: begin
                if (!div_trial[XLEN]) begin
                    rem_d   = div_trial[XLEN-1:0];
                    shreg_d = {shreg_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d   = div_part[XLEN-1:0];
                    shreg_d = {shreg_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                alu_out_d     = done_res;
                out_illegal_d = 1'b0;
                out_valid_d   = 1'b1;
                state_d       = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            neg_q         <= 1'b0;
            neg_rem_q     <= 1'b0;
            acc_q         <= '0;
            mcand_q       <= '0;
            shreg_q       <= '0;
            divisor_q     <= '0;
            rem_q         <= '0;
            alu_out_q     <= '0;
            out_illegal_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            neg_q         <= neg_d;
            neg_rem_q     <= neg_rem_d;
            acc_q         <= acc_d;
            mcand_q       <= mcand_d;
            shreg_q       <= shreg_d;
            divisor_q     <= divisor_d;
            rem_q         <= rem_d;
            alu_out_q     <= alu_out_d;
            out_illegal_q <= out_illegal_d;
            out_valid_q   <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Testbench for alu_mc: a 32-bit instance with M ops and a 16-bit instance without.
// Expected results are queued at accept and compared when each result is consumed.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [4:0]  alu_ctrl;
    logic [31:0] operand1, operand2, alu_out;

    logic        in_valid_16, in_ready_16, out_valid_16, out_ready_16, out_illegal_16;
    logic [4:0]  alu_ctrl_16;
    logic [15:0] operand1_16, operand2_16, alu_out_16;

    typedef struct {
        logic [31:0] v;
        logic        ill;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(.XLEN(32), .ENABLE_M(1'b1)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
        .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .out_illegal(out_illegal)
    );

    alu_mc #(.XLEN(16), .ENABLE_M(1'b0)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_16), .in_ready(in_ready_16), .alu_ctrl(alu_ctrl_16),
        .operand1(operand1_16), .operand2(operand2_16),
        .out_valid(out_valid_16), .out_ready(out_ready_16),
        .alu_out(alu_out_16), .out_illegal(out_illegal_16)
    );

    // Scoreboard: compare every consumed result against the oldest expectation.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            total++;
            if (q32.size() == 0) begin
                bad++;
                $display("FAIL out32_unexpected got=%h ill=%b required=no output", alu_out, out_illegal);
            end else begin
                e = q32.pop_front();
                if (alu_out !== e.v || out_illegal !== e.ill) begin
                    bad++;
                    $display("FAIL out32 got=%h ill=%b required=%h ill=%b", alu_out, out_illegal, e.v, e.ill);
                end
            end
        end
    end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst && out_valid_16 && out_ready_16) begin
            total++;
            if (q16.size() == 0) begin
                bad++;
                $display("FAIL out16_unexpected got=%h ill=%b required=no output", alu_out_16, out_illegal_16);
            end else begin
                e = q16.pop_front();
                if (alu_out_16 !== e.v[15:0] || out_illegal_16 !== e.ill) begin
                    bad++;
                    $display("FAIL out16 got=%h ill=%b required=%h ill=%b", alu_out_16, out_illegal_16, e.v[15:0], e.ill);
                end
            end
        end
    end

    // Present one op, wait for it to be accepted, queue its expected result.
    // Returns one ns after the accepting edge with in_valid dropped.
    task automatic send(input bit d16, input logic [4:0] ctrl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ev, input logic ei,
                        output int waited);
        exp_t e;
        bit   ok;
        e.v    = ev;
        e.ill  = ei;
        ok     = 1'b0;
        waited = 0;
        if (d16) begin
            in_valid_16 = 1'b1; alu_ctrl_16 = ctrl; operand1_16 = a[15:0]; operand2_16 = b[15:0];
        end else begin
            in_valid = 1'b1; alu_ctrl = ctrl; operand1 = a; operand2 = b;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((d16 ? in_ready_16 : in_ready) === 1'b1) begin
                if (d16) q16.push_back(e);
                else     q32.push_back(e);
                ok = 1'b1;
                break;
            end
            waited++;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout ctrl=%b got=no accept required=accept", ctrl);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_valid_16 = 1'b0;
    endtask

    task automatic wait_drain(input bit d16);
        int n = 0;
        while ((d16 ? q16.size() : q32.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if ((d16 ? q16.size() : q32.size()) != 0) begin
            bad++;
            $display("FAIL drain_timeout d16=%0d got=%0d pending required=0", d16, d16 ? q16.size() : q32.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1; alu_ctrl = 5'b00000; operand1 = 32'd5; operand2 = 32'd6;
        in_valid_16 = 1'b0; alu_ctrl_16 = '0; operand1_16 = '0; operand2_16 = '0;
        out_ready = 1'b1; out_ready_16 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || alu_out !== 32'd0 || in_ready !== 1'b0 || out_illegal !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs got=ov%b out%h ir%b ill%b required=ov0 out0 ir0 ill0",
                         out_valid, alu_out, in_ready, out_illegal);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1 || in_ready_16 !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b/%b required=1/1", in_ready, in_ready_16);
        end
        @(posedge clk);
        #1;
    endtask

    // Base ops back to back on either instance; each result must follow its accept by one cycle.
    task automatic test_base(input bit d16);
        logic [4:0]  c [10];
        logic [31:0] a [10];
        logic [31:0] b [10];
        logic [31:0] r [10];
        int w;
        c = '{5'b00000, 5'b01000, 5'b00100, 5'b00110, 5'b00111, 5'b00001, 5'b00101, 5'b01101, 5'b00010, 5'b00011};
        a = '{32'd20, 32'd20, 32'd20, 32'd20, 32'd20, 32'd1, 32'h80000000, 32'h80000000, 32'hFFFFFFF1, 32'hFFFFFFF1};
        b = '{32'd10, 32'd10, 32'd10, 32'd10, 32'd10, 32'd36, 32'd4, 32'd4, 32'd10, 32'd10};
        r = '{32'd30, 32'd10, 32'd30, 32'd30, 32'd0, 32'd16, 32'h08000000, 32'hF8000000, 32'd1, 32'd0};
        if (d16) begin
            a[6] = 32'h8000; a[7] = 32'h8000; r[6] = 32'h0800; r[7] = 32'hF800;
        end
        for (int i = 0; i < 10; i++) begin
            send(d16, c[i], a[i], b[i], r[i], 1'b0, w);
            total++;
            if (w != 0 || (d16 ? out_valid_16 : out_valid) !== 1'b1) begin
                bad++;
                $display("FAIL base_latency op=%0d got=wait%0d ov%b required=wait0 ov1", i, w, d16 ? out_valid_16 : out_valid);
            end
        end
        wait_drain(d16);
    endtask

    task automatic test_mul();
        int w;
        int n;
        int busy_bad;
        send(1'b0, 5'b10000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, w);
        n = 0;
        busy_bad = 0;
        while (n < 100) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) busy_bad++;
            n++;
        end
        total++;
        if (n != 33 || busy_bad != 0) begin
            bad++;
            $display("FAIL mul_latency got=%0d cycles ready_hi=%0d required=33 cycles ready_hi=0", n, busy_bad);
        end
        @(posedge clk);
        #1;
        send(1'b0, 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, w);
        send(1'b0, 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, w);
        send(1'b0, 5'b10010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, w);
        wait_drain(1'b0);
    endtask

    task automatic test_div();
        int w;
        send(1'b0, 5'b10100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 1'b0, w);
        send(1'b0, 5'b10110, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 1'b0, w);
        send(1'b0, 5'b10101, 32'd20, 32'd3, 32'd6, 1'b0, w);
        send(1'b0, 5'b10111, 32'd20, 32'd3, 32'd2, 1'b0, w);
        wait_drain(1'b0);
        send(1'b0, 5'b10100, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b0, w);
        total++;
        if (out_valid !== 1'b1 || alu_out !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL div_by_zero_latency got=ov%b %h required=ov1 ffffffff", out_valid, alu_out);
        end
        send(1'b0, 5'b10110, 32'd5, 32'd0, 32'd5, 1'b0, w);
        send(1'b0, 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, w);
        total++;
        if (out_valid !== 1'b1 || alu_out !== 32'h80000000) begin
            bad++;
            $display("FAIL div_overflow_latency got=ov%b %h required=ov1 80000000", out_valid, alu_out);
        end
        send(1'b0, 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, w);
        wait_drain(1'b0);
    endtask

    task automatic test_backpressure();
        int w;
        int n;
        out_ready = 1'b0;
        send(1'b0, 5'b10000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, w);
        n = 0;
        while (n < 100 && out_valid !== 1'b1) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || alu_out !== 32'hFFFFFFEB || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold got=ov%b %h ir%b required=ov1 ffffffeb ir0", out_valid, alu_out, in_ready);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(1'b0, 5'b00000, 32'd3, 32'd4, 32'd7, 1'b0, w);
        total++;
        if (w != 0 || out_valid !== 1'b1 || alu_out !== 32'd7) begin
            bad++;
            $display("FAIL drain_and_accept got=wait%0d ov%b %h required=wait0 ov1 7", w, out_valid, alu_out);
        end
        wait_drain(1'b0);
    endtask

    task automatic test_illegal();
        int w;
        send(1'b0, 5'b11000, 32'd1, 32'd2, 32'd0, 1'b1, w);
        total++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || alu_out !== 32'd0) begin
            bad++;
            $display("FAIL illegal_m got=ov%b ill%b %h required=ov1 ill1 0", out_valid, out_illegal, alu_out);
        end
        send(1'b0, 5'b01001, 32'd1, 32'd2, 32'd0, 1'b1, w);
        send(1'b0, 5'b00000, 32'd1, 32'd2, 32'd3, 1'b0, w);
        wait_drain(1'b0);
    endtask

    task automatic test_midop_reset();
        int w;
        int seen;
        send(1'b0, 5'b10100, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, 1'b0, w);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        q32.delete();
        q16.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midop_reset got=%0d valid cycles required=0", seen);
        end
        @(posedge clk);
        #1;
        send(1'b0, 5'b10101, 32'd20, 32'd3, 32'd6, 1'b0, w);
        wait_drain(1'b0);
    endtask

    task automatic test_param16();
        int w;
        test_base(1'b1);
        send(1'b1, 5'b10100, 32'hFFFFFFEC, 32'd3, 32'd0, 1'b1, w);
        total++;
        if (out_valid_16 !== 1'b1 || out_illegal_16 !== 1'b1) begin
            bad++;
            $display("FAIL m16_div_illegal got=ov%b ill%b required=ov1 ill1", out_valid_16, out_illegal_16);
        end
        send(1'b1, 5'b10101, 32'd20, 32'd3, 32'd0, 1'b1, w);
        send(1'b1, 5'b10000, 32'd7, 32'd3, 32'd0, 1'b1, w);
        total++;
        if (out_valid_16 !== 1'b1 || out_illegal_16 !== 1'b1 || alu_out_16 !== 16'd0) begin
            bad++;
            $display("FAIL m16_mul_illegal got=ov%b ill%b %h required=ov1 ill1 0", out_valid_16, out_illegal_16, alu_out_16);
        end
        wait_drain(1'b1);
    endtask

    initial begin
        test_reset();
        test_base(1'b0);
        test_mul();
        test_div();
        test_backpressure();
        test_illegal();
        test_midop_reset();
        test_param16();
        total++;
        if (q32.size() != 0 || q16.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d/%0d required=0/0", q32.size(), q16.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, handshaked successor to the combinational RV32I ALU.
- Parametrised datapath width; same base opcode encoding, {funct7[5], funct3}.
- Adds registered output with valid/ready flow control, plus optional iterative RV32M multiply/divide.
- Sits between decode/operand fetch and writeback; can stall the pipeline while busy.

Parameters:
- XLEN, 32, datapath width; power of two, >= 8.
- ENABLE_M, 1, 1 = implement MUL/DIV ops; 0 = those encodings flag illegal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept; transfer when in_valid && in_ready
- alu_ctrl  in  5  opcode (see Behaviour)
- operand1  in  XLEN  rs1 / dividend / multiplicand
- operand2  in  XLEN  rs2 / divisor / multiplier / shift amount
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- alu_out  out  XLEN  result
- out_illegal  out  1  unsupported opcode; alu_out = 0

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, out_valid=0, alu_out=0, out_illegal=0, in_ready=0 during the reset cycle. Reset mid-operation discards the op; no output is produced.
- Base ops, alu_ctrl[4]=0:
  - 0000 ADD, 1000 SUB, 0100 XOR, 0110 OR, 0111 AND.
  - 0001 SLL, 0101 SRL, 1101 SRA; shift amount = operand2[log2(XLEN)-1:0].
  - 0010 SLT (signed), 0011 SLTU; result is 1 or 0, zero-extended.
  - Other base codes: out_illegal=1.
  - Add/sub wrap modulo 2^XLEN.
- M ops, alu_ctrl[4]=1:
  - 10000 MUL (low half), 10001 MULH (s*s high), 10010 MULHSU (s*u high), 10011 MULHU (u*u high).
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - 11xxx, or any M op with ENABLE_M=0: out_illegal=1.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back accepts are allowed when the output drains the same cycle.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE + accept of base, illegal or special-case div -> result registered, out_valid=1 next edge (latency 1); stay IDLE.
  - IDLE + accept of mul -> MUL.
    - Shift-add, one multiplier bit per cycle, XLEN iterations on a 2*XLEN accumulator.
    - Operands are sign-handled per variant: magnitude multiply, then a conditional negate of the 2*XLEN product.
  - IDLE + accept of div/rem -> DIV.
    - Restoring division on magnitudes, one quotient bit per cycle, XLEN iterations.
    - Signs fixed at the end: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - MUL/DIV iteration counter reaching XLEN-1 -> DONE.
  - DONE: load alu_out, out_valid=1 -> IDLE.
  - Latency from accept edge k to out_valid rising at edge k+XLEN+1.
- Division special cases, latency 1 with no iteration:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = operand1.
  - Signed overflow (operand1 = most-negative, operand2 = -1): DIV = operand1; REM = 0.
- Output hold: alu_out, out_illegal and out_valid stay stable while out_valid && !out_ready. in_valid is ignored while in_ready=0.
- Operands and opcode are captured at accept; input changes during MUL/DIV have no effect.
- out_valid drops the edge after handshake unless a new base op was accepted in the same cycle.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, alu_out=0, in_ready=0 in those cycles; in_ready=1 the cycle after rst falls.
- Base ops, XLEN=32, out_ready=1, one op per cycle:
  - ADD 20,10 -> 30; SUB 20,10 -> 10; XOR 20,10 -> 30; AND 20,10 -> 0.
  - SLL 1,36 -> 16 (shamt masked to 4); SRA 0x80000000,4 -> 0xF8000000.
  - SLT -15,10 -> 1; SLTU 0xFFFFFFF1,10 -> 0.
  - Each result appears 1 cycle after accept, with no bubbles.
- Multiply, XLEN=32:
  - MUL 7,-3 -> 0xFFFFFFEB, out_valid exactly 33 cycles after accept, in_ready=0 meanwhile.
  - MULH -1,-1 -> 0; MULHU 0xFFFFFFFF,0xFFFFFFFF -> 0xFFFFFFFE; MULHSU -1,2 -> 0xFFFFFFFF.
- Divide:
  - DIV -20,3 -> -6; REM -20,3 -> -2; DIVU 20,3 -> 6; REMU 20,3 -> 2.
  - DIV 5,0 -> 0xFFFFFFFF at latency 1; REM 5,0 -> 5.
  - DIV 0x80000000,-1 -> 0x80000000; REM -> 0.
- Backpressure: hold out_ready=0 for 5 cycles after a MUL result -> alu_out stable, in_ready=0; raising out_ready with in_valid=1 ADD accepts the new op the same cycle.
- Illegal and mid-op reset: alu_ctrl=11000 -> out_illegal=1, alu_out=0 at latency 1. Assert rst on cycle 10 of a DIV -> no out_valid afterwards; next op completes normally.
- Parametrisation: rerun the base and divide cases at XLEN=16 with ENABLE_M=0 -> base results correct, MUL flags out_illegal.
